// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC, imem request/response, 2-entry fetch queue.
// Optional perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] fetch_inst,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_outst;
  logic        r_kill;
  logic [1:0]  r_cnt;
  logic [31:0] r_q_inst [2];
  logic [31:0] r_q_pc4  [2];
  logic [31:0] r_if_id_inst;
  logic [31:0] r_if_id_pc4;
  logic        r_if_id_valid;

  logic        w_rsp;
  logic        w_push;
  logic        w_pop;
  logic        w_acc;
  logic        w_wr_idx;
  logic [1:0]  w_cnt_nxt;
  logic [31:0] w_redir_pc;

  assign w_rsp      = imem_rsp_valid & r_outst;
  assign w_push     = w_rsp & ~r_kill & ~redirect_valid;
  assign w_pop      = ~stall & (r_cnt != 2'd0);
  assign w_cnt_nxt  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  // Slot for a push once the optional pop has shifted the head out.
  assign w_wr_idx   = r_cnt[0] ^ w_pop;
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req_valid = rst_n & ~redirect_valid & ~r_kill
                        & (~r_outst | imem_rsp_valid)
                        & ~w_cnt_nxt[1];
  assign w_acc      = imem_req_valid & imem_req_ready;
  assign imem_addr  = r_pc;

  assign fetch_inst  = (r_cnt != 2'd0) ? r_q_inst[0] : 32'd0;
  assign if_id_inst  = r_if_id_inst;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_req_pc <= 32'd0;
      r_outst  <= 1'b0;
      r_kill   <= 1'b0;
    end else begin
      if (redirect_valid)
        r_pc <= w_redir_pc;
      else if (w_acc)
        r_pc <= r_pc + 32'd4;
      if (w_acc)
        r_req_pc <= r_pc;
      if (w_acc)
        r_outst <= 1'b1;
      else if (w_rsp)
        r_outst <= 1'b0;
      // A redirect with the response still in flight must discard it later.
      if (w_rsp)
        r_kill <= 1'b0;
      else if (redirect_valid & r_outst)
        r_kill <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else if (redirect_valid) begin
      r_cnt <= 2'd0;
    end else begin
      if (w_pop) begin
        r_q_inst[0] <= r_q_inst[1];
        r_q_pc4[0]  <= r_q_pc4[1];
      end
      if (w_push) begin
        r_q_inst[w_wr_idx] <= imem_rsp_data;
        r_q_pc4[w_wr_idx]  <= r_req_pc + 32'd4;
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      r_if_id_inst  <= 32'd0;
      r_if_id_pc4   <= 32'd0;
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (r_cnt != 2'd0) begin
        r_if_id_inst  <= r_q_inst[0];
        r_if_id_pc4   <= r_q_pc4[0];
        r_if_id_valid <= 1'b1;
      end else begin
        r_if_id_inst  <= 32'd0;
        r_if_id_pc4   <= 32'd0;
        r_if_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (stall & r_if_id_valid & ~&r_perf_stall)
        r_perf_stall <= r_perf_stall + 32'd1;
      if (redirect_valid & ~&r_perf_flush)
        r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus reset/stray-response sequence.
// Memory model answers one cycle after acceptance unless held.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] fetch_inst;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_inst     (fetch_inst),
    .if_id_inst     (if_id_inst),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        hold;
    logic        e_rv;
    logic [31:0] e_addr;
    logic [31:0] e_fetch;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_v;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;

  function automatic logic [31:0] D(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  function automatic vec_t mk(
    input logic rst, input logic stl, input logic rdr,
    input logic [31:0] rpc, input logic rdy, input logic hold,
    input logic e_rv, input logic [31:0] e_addr,
    input logic [31:0] e_fetch, input logic [31:0] e_inst,
    input logic [31:0] e_pc4, input logic e_v);
    vec_t t;
    t.rst = rst; t.stl = stl; t.rdr = rdr; t.rpc = rpc;
    t.rdy = rdy; t.hold = hold; t.e_rv = e_rv; t.e_addr = e_addr;
    t.e_fetch = e_fetch; t.e_inst = e_inst; t.e_pc4 = e_pc4; t.e_v = e_v;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One cycle: memory response, drive inputs, check, record acceptance.
  task automatic run(input vec_t t, input logic full);
    @(negedge clk);
    if (pend && !t.hold) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = D(pend_addr);
      pend = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    rst_n          = t.rst;
    stall          = t.stl;
    redirect_valid = t.rdr;
    redirect_pc    = t.rpc;
    imem_req_ready = t.rdy;
    #1;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, t.e_rv});
    if (full) begin
      chk("addr",     imem_addr,  t.e_addr);
      chk("fetch",    fetch_inst, t.e_fetch);
      chk("if_id",    if_id_inst, t.e_inst);
      chk("pc4",      if_id_pc4,  t.e_pc4);
      chk("valid",    {31'd0, if_id_valid}, {31'd0, t.e_v});
    end
    if (imem_req_valid && imem_req_ready) begin
      pend = 1'b1;
      pend_addr = imem_addr;
    end
    cyc++;
  endtask

  vec_t tbl[26];

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;

    // straight-line fetch
    tbl[0]  = mk(1,0,0,0,1,0, 1,32'h00,0,0,0,0);
    tbl[1]  = mk(1,0,0,0,1,0, 1,32'h04,0,0,0,0);
    tbl[2]  = mk(1,0,0,0,1,0, 1,32'h08,D(32'h00),0,0,0);
    tbl[3]  = mk(1,0,0,0,1,0, 1,32'h0C,D(32'h04),D(32'h00),32'h04,1);
    tbl[4]  = mk(1,0,0,0,1,0, 1,32'h10,D(32'h08),D(32'h04),32'h08,1);
    tbl[5]  = mk(1,0,0,0,1,0, 1,32'h14,D(32'h0C),D(32'h08),32'h0C,1);
    // stall with queue filling to 2
    tbl[6]  = mk(1,1,0,0,1,0, 0,32'h18,D(32'h10),D(32'h0C),32'h10,1);
    tbl[7]  = mk(1,1,0,0,1,0, 0,32'h18,D(32'h10),D(32'h0C),32'h10,1);
    tbl[8]  = mk(1,1,0,0,1,0, 0,32'h18,D(32'h10),D(32'h0C),32'h10,1);
    tbl[9]  = mk(1,0,0,0,1,0, 1,32'h18,D(32'h10),D(32'h0C),32'h10,1);
    tbl[10] = mk(1,0,0,0,1,0, 1,32'h1C,D(32'h14),D(32'h10),32'h14,1);
    tbl[11] = mk(1,0,0,0,1,0, 1,32'h20,D(32'h18),D(32'h14),32'h18,1);
    // redirect with 0x20 outstanding, its response arrives late
    tbl[12] = mk(1,0,1,32'h103,1,1, 0,32'h24,D(32'h1C),D(32'h18),32'h1C,1);
    tbl[13] = mk(1,0,0,0,1,0, 0,32'h100,0,0,0,0);
    tbl[14] = mk(1,0,0,0,1,0, 1,32'h100,0,0,0,0);
    tbl[15] = mk(1,0,0,0,1,0, 1,32'h104,0,0,0,0);
    tbl[16] = mk(1,0,0,0,1,0, 1,32'h108,D(32'h100),0,0,0);
    tbl[17] = mk(1,0,0,0,1,0, 1,32'h10C,D(32'h104),D(32'h100),32'h104,1);
    // redirect and stall together, response lands in the redirect cycle
    tbl[18] = mk(1,1,1,32'h200,1,0, 0,32'h110,D(32'h108),D(32'h104),32'h108,1);
    tbl[19] = mk(1,0,0,0,1,0, 1,32'h200,0,0,0,0);
    // ready held low for 4 cycles
    tbl[20] = mk(1,0,0,0,0,0, 1,32'h204,0,0,0,0);
    tbl[21] = mk(1,0,0,0,0,0, 1,32'h204,D(32'h200),0,0,0);
    tbl[22] = mk(1,0,0,0,0,0, 1,32'h204,0,D(32'h200),32'h204,1);
    tbl[23] = mk(1,0,0,0,0,0, 1,32'h204,0,0,0,0);
    tbl[24] = mk(1,0,0,0,1,0, 1,32'h204,0,0,0,0);
    tbl[25] = mk(1,0,0,0,1,0, 1,32'h208,0,0,0,0);

    run(mk(0,0,0,0,1,0, 0,0,0,0,0,0), 1'b0);
    run(mk(0,0,0,0,1,0, 0,0,0,0,0,0), 1'b0);
    for (int i = 0; i < 26; i++)
      run(tbl[i], 1'b1);

    // reset with 0x208 outstanding, then its stray response
    run(mk(0,0,0,0,1,1, 0,0,0,0,0,0), 1'b0);
    run(mk(1,0,0,0,1,0, 1,32'h00,0,0,0,0), 1'b1);
    run(mk(1,0,0,0,1,0, 1,32'h04,0,0,0,0), 1'b1);
    run(mk(1,0,0,0,1,0, 1,32'h08,D(32'h00),0,0,0), 1'b1);
    run(mk(1,0,0,0,1,0, 1,32'h0C,D(32'h04),D(32'h00),32'h04,1), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
